pmem_responder: RTL
===================

PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width.
REQ-002 Parameter DATA_W, default 256, line width in bits (one line per transaction).
REQ-003 Parameter DEPTH, default 256, number of stored lines (power of two).
REQ-004 Parameter LATENCY, default 4, accept-to-response cycles (legal range 2..15).
REQ-005 Parameter REFRESH_PERIOD, default 64, cycles between refresh requests.
REQ-006 Parameter REFRESH_CYCLES, default 3, cycles one refresh occupies.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 mem_action_stb  in  1  request strobe from the cache controller.
REQ-011 mem_action_cyc  in  1  bus cycle valid from the cache controller.
REQ-012 mem_write  in  1  1 = write line, 0 = read line.
REQ-013 mem_address  in  ADDR_W  byte address; line index = mem_address[OFF+IDX_W-1:OFF], OFF = log2(DATA_W/8), IDX_W = log2(DEPTH).
REQ-014 mem_wdata  in  DATA_W  write line data.
REQ-015 mem_rdata  out  DATA_W  read line data.
REQ-016 mem_resp  out  1  one-cycle completion pulse.
REQ-017 mem_retry  out  1  request refused this cycle; the initiator re-presents the request.

Function
REQ-018 A request SHALL be present when mem_action_stb & mem_action_cyc = 1.
REQ-019 States SHALL be IDLE, BUSY, RESP and REFRESH.
REQ-020 IDLE, request present, no refresh pending: accept; capture write, index and wdata; load the latency counter with LATENCY-2; go to BUSY.
REQ-021 BUSY: decrement every cycle; at 0 go to RESP; captured attributes SHALL be used; input changes are ignored.
REQ-022 BUSY, request withdrawn (stb or cyc low): abort to IDLE next cycle; no resp; no array write.
REQ-023 RESP SHALL last exactly one cycle: mem_resp = 1. For a write, array[index] <= captured wdata at the end of that cycle. For a read, mem_rdata = array[index] during RESP. Next state is IDLE.
REQ-024 Latency: request accepted in IDLE at cycle T -> mem_resp high in cycle T+LATENCY.
REQ-025 mem_rdata SHALL hold the last read line until the next read RESP; writes SHALL leave mem_rdata unchanged.
REQ-026 A request present in the cycle after RESP SHALL be treated as new and accepted from IDLE.
REQ-027 Refresh counter: free-running 0..REFRESH_PERIOD-1; at wrap it sets refresh_pending.
REQ-028 IDLE with refresh_pending SHALL enter REFRESH and clear pending, even when a request is present; refresh has priority.
REQ-029 Refresh pending during BUSY/RESP SHALL be held; the transaction completes first and REFRESH follows via IDLE.
REQ-030 REFRESH SHALL last REFRESH_CYCLES cycles, then return to IDLE.
REQ-031 mem_retry = 1 combinationally whenever a request is present and the next state is not BUSY from IDLE, and the state is IDLE-with-pending or REFRESH. Otherwise mem_retry = 0.
REQ-032 mem_resp and mem_retry SHALL never be high in the same cycle.
REQ-033 Address bits outside the index field SHALL be ignored (aliasing wraps modulo DEPTH).
REQ-034 Array contents SHALL not be reset; reads of unwritten lines return undefined data.

Reset
REQ-035 rst_n low SHALL asynchronously force: state IDLE, mem_resp 0, mem_retry 0 (combinational from state), mem_rdata 0, latency counter 0, refresh counter 0, refresh_pending 0.
REQ-036 Reset mid-BUSY SHALL discard the transaction with no array write and no resp after release.
REQ-037 The first refresh SHALL become pending REFRESH_PERIOD cycles after reset release.

Verification
REQ-038 Write 0xA5..A5 to address 0x0000_0040, then read it -> each mem_resp arrives 4 cycles after acceptance; the read returns 0xA5..A5.
REQ-039 Write to 0x0000_0020, then read 0x0000_2020 (DEPTH 256, same index) -> the read returns the written data (alias).
REQ-040 Request held high in cycle 63 after reset -> mem_retry = 1 for 3 cycles (REFRESH) plus the pending cycle; acceptance in the following IDLE; resp 4 cycles later.
REQ-041 Write accepted, then stb dropped in the second BUSY cycle -> no mem_resp; a later read of that line returns the prior contents.
REQ-042 rst_n pulsed low during a BUSY write -> outputs are zero immediately; no resp after release; the line is unchanged.
REQ-043 Back-to-back reads with a request re-presented the cycle after RESP -> accepted immediately; mem_resp pulses are exactly 1 cycle wide and 5 cycles apart.

Source files
------------

// File: rtl/pmem_responder.sv
// pmem_responder: single-port line memory answering cache-controller
// requests after a fixed latency, with periodic refresh windows during which
// new requests are refused with a retry indication.
module pmem_responder #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 256,
    parameter int DEPTH          = 256,
    parameter int LATENCY        = 4,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_action_stb,
    input  logic              mem_action_cyc,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              mem_retry
);

    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int RP_W  = $clog2(REFRESH_PERIOD);
    localparam int RD_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_REFRESH
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        lat_cnt_reg, lat_cnt_next;
    logic [RD_W-1:0]   ref_dur_reg, ref_dur_next;
    logic [RP_W-1:0]   ref_cnt_reg;
    logic              ref_pending_reg;

    // Attributes captured at acceptance; inputs are ignored afterwards.
    logic              wr_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic [IDX_W-1:0]  idx_in;
    logic              accept;
    logic              enter_refresh;
    logic              rd_fire;
    logic              ref_wrap;
    logic              unused_addr;

    assign req         = mem_action_stb & mem_action_cyc;
    // Only the line-index field selects a line; everything else aliases.
    assign idx_in      = mem_address[OFF +: IDX_W];
    assign unused_addr = ^mem_address;
    assign ref_wrap    = (ref_cnt_reg == RP_W'(REFRESH_PERIOD - 1));
    assign mem_rdata   = rdata_reg;

    // State, latency and refresh-duration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            lat_cnt_reg <= '0;
            ref_dur_reg <= '0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            ref_dur_reg <= ref_dur_next;
        end
    end

    // Next-state logic and the combinational resp/retry outputs.
    always_comb begin
        state_next    = state_reg;
        lat_cnt_next  = lat_cnt_reg;
        ref_dur_next  = ref_dur_reg;
        accept        = 1'b0;
        enter_refresh = 1'b0;
        rd_fire       = 1'b0;
        mem_resp      = 1'b0;
        mem_retry     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Refresh wins over a waiting request.
                if (ref_pending_reg) begin
                    state_next    = ST_REFRESH;
                    enter_refresh = 1'b1;
                    ref_dur_next  = RD_W'(REFRESH_CYCLES - 1);
                    mem_retry     = req;
                end else if (req) begin
                    state_next   = ST_BUSY;
                    accept       = 1'b1;
                    lat_cnt_next = 4'(LATENCY - 2);
                end
            end
            ST_BUSY: begin
                if (!req) begin
                    state_next = ST_IDLE;
                end else if (lat_cnt_reg == '0) begin
                    state_next = ST_RESP;
                    // Launch the array read so the line is registered for RESP.
                    rd_fire    = ~wr_reg;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                mem_resp   = 1'b1;
                state_next = ST_IDLE;
            end
            ST_REFRESH: begin
                mem_retry = req;
                if (ref_dur_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    ref_dur_next = ref_dur_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Free-running refresh counter; a wrap raises pending until REFRESH is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_reg     <= '0;
            ref_pending_reg <= 1'b0;
        end else begin
            if (ref_wrap) begin
                ref_cnt_reg <= '0;
            end else begin
                ref_cnt_reg <= ref_cnt_reg + 1'b1;
            end
            if (ref_wrap) begin
                ref_pending_reg <= 1'b1;
            end else if (enter_refresh) begin
                ref_pending_reg <= 1'b0;
            end
        end
    end

    // Capture the transaction attributes on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_reg    <= mem_write;
            idx_reg   <= idx_in;
            wdata_reg <= mem_wdata;
        end
    end

    // Line array write at the end of a write RESP; contents are never reset.
    always_ff @(posedge clk) begin
        if (state_reg == ST_RESP && wr_reg) begin
            mem[idx_reg] <= wdata_reg;
        end
    end

    // Registered read data; holds the last read line across writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (rd_fire) begin
            rdata_reg <= mem[idx_reg];
        end
    end

endmodule
